// File: rtl/video_mode_proc.sv
// video_mode_proc -- pixel-stream processor sitting between HDMI RX and TX
// (rx_clk domain). Applies a per-frame mode to CH_NUM x CH_W pixels with a
// fixed 3-cycle latency, delays de/hsync/vsync to match, and optionally
// measures the active width/height of each frame.
//
// Optional feature macro: VIDEO_PROC_STATS_EN (measurement logic). When it is
// undefined the four frame_* outputs are tied to 0.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   rgb_in, de, hsync, vsync   input stream, rgb_in = {.., ch1, ch0}
//   mode_in, thresh_in  0 pass / 1 gray / 2 threshold / 3 invert, threshold;
//                       both sampled on the vsync rising edge
//   rgb_out, de_out, hsync_out, vsync_out   stream delayed by 3 clk
//   frame_width, frame_height, frame_valid, frame_stable   last frame stats
module video_mode_proc #(
  parameter int CH_NUM = 3,
  parameter int CH_W   = 8,
  parameter int CNT_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_NUM*CH_W-1:0] rgb_in,
  input  logic                   de,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [1:0]             mode_in,
  input  logic [CH_W-1:0]        thresh_in,
  output logic [CH_NUM*CH_W-1:0] rgb_out,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [CNT_W-1:0]       frame_width,
  output logic [CNT_W-1:0]       frame_height,
  output logic                   frame_valid,
  output logic                   frame_stable
);
  localparam int PW = CH_NUM * CH_W;
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;
  localparam bit GRAY_EN = (CH_NUM == 3);

  logic              vs_prev_q, vs_rise;
  logic [1:0]        mode_q, mode_d;
  logic [CH_W-1:0]   thr_q, thr_d;
  logic [2:0]        vld_pipe_q, vld_pipe_d;
  logic [2:0]        hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic [PW-1:0]     rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d, rgb_out_q, rgb_out_d;
  logic [1:0]        mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic [CH_W-1:0]   thr_s1_q, thr_s1_d, thr_s2_q, thr_s2_d, g_s2_q, g_s2_d;
  logic [CH_NUM-1:0][CH_W-1:0] ch_out_d;

  // The pixel arriving with the vsync rising edge already uses the newly
  // captured mode, so the shadow value is bypassed on that cycle.
  always_comb begin
    vs_rise    = vsync & ~vs_prev_q;
    mode_d     = vs_rise ? mode_in : mode_q;
    thr_d      = vs_rise ? thresh_in : thr_q;
    vld_pipe_d = {vld_pipe_q[1:0], de};
    hs_pipe_d  = {hs_pipe_q[1:0], hsync};
    vs_pipe_d  = {vs_pipe_q[1:0], vsync};
    rgb_s1_d   = rgb_in;
    mode_s1_d  = mode_d;
    thr_s1_d   = thr_d;
    rgb_s2_d   = rgb_s1_q;
    mode_s2_d  = mode_s1_q;
    thr_s2_d   = thr_s1_q;
    rgb_out_d  = ch_out_d;
  end

  // Luma-ish gray: (ch0 + 2*ch1 + ch2) >> 2 computed 2 bits wider, cannot overflow.
  generate
    if (GRAY_EN) begin : g_gray
      logic [CH_W+1:0] g_sum;
      assign g_sum  = {2'b00, rgb_s1_q[0 +: CH_W]} + {1'b0, rgb_s1_q[CH_W +: CH_W], 1'b0}
                    + {2'b00, rgb_s1_q[2*CH_W +: CH_W]};
      assign g_s2_d = g_sum[CH_W+1:2];
    end else begin : g_nogray
      assign g_s2_d = '0;
    end
  endgenerate

  genvar c;
  generate
    for (c = 0; c < CH_NUM; c++) begin : g_ch
      logic [CH_W-1:0] ch_in, ch_res;
      assign ch_in = rgb_s2_q[c*CH_W +: CH_W];
      always_comb begin
        ch_res = ch_in;
        case (mode_s2_q)
          MODE_GRAY: if (GRAY_EN) ch_res = g_s2_q;
          MODE_THR:  if (GRAY_EN) ch_res = {CH_W{g_s2_q >= thr_s2_q}};
          MODE_INV:  ch_res = ~ch_in;
          default:   ch_res = ch_in;
        endcase
        // blank outside active video
        if (!vld_pipe_q[1]) ch_res = '0;
      end
      assign ch_out_d[c] = ch_res;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q  <= 1'b0;
      mode_q     <= MODE_PASS;
      thr_q      <= '0;
      vld_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      rgb_s1_q   <= '0;
      rgb_s2_q   <= '0;
      rgb_out_q  <= '0;
      mode_s1_q  <= MODE_PASS;
      mode_s2_q  <= MODE_PASS;
      thr_s1_q   <= '0;
      thr_s2_q   <= '0;
      g_s2_q     <= '0;
    end else begin
      vs_prev_q  <= vsync;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      vld_pipe_q <= vld_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      rgb_s1_q   <= rgb_s1_d;
      rgb_s2_q   <= rgb_s2_d;
      rgb_out_q  <= rgb_out_d;
      mode_s1_q  <= mode_s1_d;
      mode_s2_q  <= mode_s2_d;
      thr_s1_q   <= thr_s1_d;
      thr_s2_q   <= thr_s2_d;
      g_s2_q     <= g_s2_d;
    end
  end

  assign rgb_out   = rgb_out_q;
  assign de_out    = vld_pipe_q[2];
  assign hsync_out = hs_pipe_q[2];
  assign vsync_out = vs_pipe_q[2];

`ifdef VIDEO_PROC_STATS_EN
  logic             de_prev_q, de_fall, armed_q, armed_d, stable_q, stable_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, line_cnt_q, line_cnt_d, ref_w_q, ref_w_d;
  logic [CNT_W-1:0] fw_q, fw_d, fh_q, fh_d;
  logic             fv_q, fv_d, fs_q, fs_d;

  // Line bookkeeping is resolved before the publish check so a de falling
  // edge coinciding with the vsync rising edge still counts its line.
  always_comb begin
    de_fall    = de_prev_q & ~de;
    h_cnt_d    = h_cnt_q;
    line_cnt_d = line_cnt_q;
    ref_w_d    = ref_w_q;
    stable_d   = stable_q;
    armed_d    = armed_q;
    fw_d       = fw_q;
    fh_d       = fh_q;
    fv_d       = fv_q;
    fs_d       = fs_q;
    if (de && h_cnt_q != '1) h_cnt_d = h_cnt_q + 1'b1;
    if (de_fall) begin
      if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
      if (line_cnt_q == '0)          ref_w_d  = h_cnt_q;
      else if (h_cnt_q != ref_w_q)   stable_d = 1'b0;
      h_cnt_d = '0;
    end
    if (vs_rise) begin
      // a frame without any de line leaves the published values untouched
      if (armed_q && line_cnt_d != '0) begin
        fw_d = ref_w_d;
        fh_d = line_cnt_d;
        fs_d = stable_d;
        fv_d = 1'b1;
      end
      armed_d    = 1'b1;
      h_cnt_d    = '0;
      line_cnt_d = '0;
      ref_w_d    = '0;
      stable_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      stable_q   <= 1'b0;
      h_cnt_q    <= '0;
      line_cnt_q <= '0;
      ref_w_q    <= '0;
      fw_q       <= '0;
      fh_q       <= '0;
      fv_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      de_prev_q  <= de;
      armed_q    <= armed_d;
      stable_q   <= stable_d;
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
      ref_w_q    <= ref_w_d;
      fw_q       <= fw_d;
      fh_q       <= fh_d;
      fv_q       <= fv_d;
      fs_q       <= fs_d;
    end
  end

  assign frame_width  = fw_q;
  assign frame_height = fh_q;
  assign frame_valid  = fv_q;
  assign frame_stable = fs_q;
`else
  assign frame_width  = '0;
  assign frame_height = '0;
  assign frame_valid  = 1'b0;
  assign frame_stable = 1'b0;
`endif

endmodule

// File: tb/tb_video_mode_proc.sv
// Scoreboard bench for video_mode_proc: every input cycle with de/hsync/vsync
// high queues its expected output; a monitor pops on each output cycle and
// also checks the 3-cycle latency. Frame statistics are checked directly.
module tb_video_mode_proc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] rgb_in, rgb_out;
  logic        de, hsync, vsync, de_out, hsync_out, vsync_out;
  logic [1:0]  mode_in;
  logic [7:0]  thresh_in;
  logic [11:0] frame_width, frame_height;
  logic        frame_valid, frame_stable;

  video_mode_proc #(.CH_NUM(3), .CH_W(8), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in), .de(de), .hsync(hsync), .vsync(vsync),
    .mode_in(mode_in), .thresh_in(thresh_in), .rgb_out(rgb_out), .de_out(de_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_width(frame_width),
    .frame_height(frame_height), .frame_valid(frame_valid), .frame_stable(frame_stable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] rgb;
    logic        de, hs, vs;
    int          cyc;
  } item_t;

  item_t sb[$];
  int    cyc    = 0;
  int    n_vec  = 0;
  int    n_bad  = 0;

  always @(posedge clk) cyc++;

  // monitor
  always @(negedge clk) begin
    if (rst_n && (de_out || hsync_out || vsync_out)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got rgb=%h de=%b hs=%b vs=%b, required no output",
                 rgb_out, de_out, hsync_out, vsync_out);
      end else begin
        item_t it;
        it = sb.pop_front();
        if (rgb_out !== it.rgb || de_out !== it.de || hsync_out !== it.hs ||
            vsync_out !== it.vs || (cyc - it.cyc) != 3) begin
          n_bad++;
          $display("FAIL stream: got rgb=%h de=%b hs=%b vs=%b lat=%0d, required rgb=%h de=%b hs=%b vs=%b lat=3",
                   rgb_out, de_out, hsync_out, vsync_out, cyc - it.cyc, it.rgb, it.de, it.hs, it.vs);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rgb"}, {8'h0, rgb_out}, 32'h0);
    chk({name, "_sync"}, {29'h0, de_out, hsync_out, vsync_out}, 32'h0);
    chk({name, "_stats"}, {6'h0, frame_width, frame_height, frame_valid, frame_stable}, 32'h0);
  endtask

  // one input cycle; called at posedge+1, returns at the next posedge+1
  task automatic drive(input logic [23:0] px, input logic d, input logic h, input logic v,
                       input logic [23:0] exp);
    item_t it;
    rgb_in = px; de = d; hsync = h; vsync = v;
    if (d || h || v) begin
      it.rgb = d ? exp : 24'h0; it.de = d; it.hs = h; it.vs = v; it.cyc = cyc;
      sb.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic vs_pulse();
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0);
    idle(2);
  endtask

  // inverted-mode line of w pixels
  task automatic line(input int w);
    for (int i = 0; i < w; i++) drive(24'h0F0F0F, 1'b1, 1'b0, 1'b0, 24'hF0F0F0);
    idle(2);
  endtask

  task automatic chk_stats(input string name, input logic [11:0] w, input logic [11:0] h,
                           input logic v, input logic s);
`ifdef VIDEO_PROC_STATS_EN
    chk({name, "_width"},  {20'h0, frame_width},  {20'h0, w});
    chk({name, "_height"}, {20'h0, frame_height}, {20'h0, h});
    chk({name, "_valid"},  {31'h0, frame_valid},  {31'h0, v});
    chk({name, "_stable"}, {31'h0, frame_stable}, {31'h0, s});
`else
    chk({name, "_width"},  {20'h0, frame_width},  32'h0);
    chk({name, "_height"}, {20'h0, frame_height}, 32'h0);
    chk({name, "_valid"},  {31'h0, frame_valid},  32'h0);
    chk({name, "_stable"}, {31'h0, frame_stable}, 32'h0);
    if (w == 12'hFFF && h == 12'hFFF && v && s) $display("unused stats arguments");
`endif
  endtask

  initial begin
    rst_n = 1'b0; rgb_in = '0; de = 0; hsync = 0; vsync = 0; mode_in = 2'd0; thresh_in = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // mode 0 pass-through with delayed syncs
    vs_pulse();
    drive(24'h123456, 1'b1, 1'b1, 1'b0, 24'h123456);
    idle(3);
    drive(24'h0, 1'b0, 1'b1, 1'b0, 24'h0);
    idle(3);

    // async reset in the middle of a line
    drive(24'hAAAAAA, 1'b1, 1'b0, 1'b0, 24'hAAAAAA);
    drive(24'hAAAAAA, 1'b1, 1'b0, 1'b0, 24'hAAAAAA);
    rgb_in = 24'hAAAAAA; de = 1'b1;
    #2 rst_n = 1'b0;
    sb.delete();
    #1 chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(24'h111111, 1'b1, 1'b0, 1'b0, 24'h111111);
    drive(24'h222222, 1'b1, 1'b0, 1'b0, 24'h222222);
    idle(4);

    // gray and threshold
    mode_in = 2'd1; vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b0, 1'b0, 24'h808080); idle(2);
    mode_in = 2'd2; thresh_in = 8'h80; vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b0, 1'b0, 24'hFFFFFF); idle(2);
    thresh_in = 8'h81; vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b0, 1'b0, 24'h000000); idle(2);

    // mid-frame mode change is ignored until the next vsync edge
    mode_in = 2'd0; vs_pulse();
    drive(24'h00FF00, 1'b1, 1'b0, 1'b0, 24'h00FF00); idle(2);
    mode_in = 2'd3;
    drive(24'h00FF00, 1'b1, 1'b0, 1'b0, 24'h00FF00); idle(2);
    vs_pulse();
    drive(24'h00FF00, 1'b1, 1'b0, 1'b0, 24'hFF00FF); idle(2);

    // two 8x4 frames, then one with a short third line
    vs_pulse();
    for (int l = 0; l < 4; l++) line(8);
    vs_pulse();
    chk_stats("frame8x4", 12'd8, 12'd4, 1'b1, 1'b1);
    for (int l = 0; l < 4; l++) line(l == 2 ? 7 : 8);
    vs_pulse();
    chk_stats("short_line", 12'd8, 12'd4, 1'b1, 1'b0);

    // frame without any active line keeps previous results
    idle(5);
    vs_pulse();
    chk_stats("empty_frame", 12'd8, 12'd4, 1'b1, 1'b0);

    begin
      int t = 0;
      while (sb.size() != 0 && t < 10) begin @(posedge clk); t++; end
      #1;
      n_vec++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d pending outputs, required 0", sb.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
